hash_table_client: RTL and testbench
====================================

HASH_TABLE_CLIENT -- requirements
Module: hash_table_client

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, width of key.
REQ-002 SHALL have parameter VALUE_WIDTH, default 32, width of value.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command queue depth, power of 2, >=2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles waiting for ht_op_done.
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue not full.
- cmd_op  in  2  00 insert, 01 delete, 10 search, 11 illegal.
- cmd_key  in  KEY_WIDTH  command key.
- cmd_value  in  VALUE_WIDTH  insert value.
- ht_key_in  out  KEY_WIDTH  key to hash table.
- ht_value_in  out  VALUE_WIDTH  value to hash table.
- ht_op_sel  out  2  opcode to hash table.
- ht_op_en  out  1  operation start pulse.
- ht_value_out  in  VALUE_WIDTH  read data from table.
- ht_op_done  in  1  table completion pulse.
- ht_op_error  in  1  table FULL / KEY_NOT_FOUND.
- ht_collision_count  in  CNT_W  chain occupancy from table, CNT_W = clog2(CHAINING_SIZE-1), from package.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_op  out  2  echoed opcode.
- rsp_key  out  KEY_WIDTH  echoed key.
- rsp_value  out  VALUE_WIDTH  search result, else 0.
- rsp_status  out  2  00 OK, 01 TABLE_ERROR, 10 TIMEOUT, 11 ILLEGAL_OP.
- busy  out  1  high when not IDLE or queue non-empty.

Function
REQ-006 Command handshake SHALL occur on cycle with cmd_valid && cmd_ready; queue is FIFO ordered, CMD_DEPTH entries; cmd_ready low only when full.
REQ-007 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one command in flight at a time.
REQ-008 IDLE: queue non-empty -> pop head into in-flight register; op 11 -> RESP with status 11 (never issued); else -> ISSUE.
REQ-009 ISSUE: ht_op_en high exactly this one cycle -> WAIT; timeout counter cleared.
REQ-010 ht_key_in, ht_value_in, ht_op_sel SHALL hold in-flight values stable from ISSUE through the cycle after ht_op_done (table reads key continuously).
REQ-011 WAIT: ht_op_done=1 -> capture status (ht_op_error ? 01 : 00), rsp_value = (op==10 && !ht_op_error) ? ht_value_out : 0 -> RESP.
REQ-012 WAIT: counter reaching TIMEOUT_CYCLES without ht_op_done -> RESP with status 10, rsp_value 0; a later stray ht_op_done SHALL be ignored.
REQ-013 RESP: rsp_valid high, rsp_* stable until rsp_ready; on handshake -> IDLE.
REQ-014 ht_op_en SHALL never rise earlier than 2 cycles after an ht_op_done cycle (table needs OP_DONE->IDLE); RESP+IDLE guarantees this.
REQ-015 Empty-queue latency: ht_op_en high in 2nd cycle after cmd handshake cycle.
REQ-016 Simultaneous push and pop on full queue: pop frees entry, cmd_ready reflects registered count (no same-cycle pass-through).
REQ-017 ht_op_en SHALL be 0 outside ISSUE; ht_op_sel unused code 11 never driven.

Reset
REQ-018 rst SHALL be sampled on clk rising edge; mid-operation reset aborts in-flight command, no response emitted.
REQ-019 After reset: state IDLE, queue empty, cmd_ready=1, ht_op_en=0, rsp_valid=0, busy=0, all data outputs 0, rsp_status 00.

Structure
REQ-020 Package hash_table_pkg SHALL hold opcode constants (OP_INSERT, OP_DELETE, OP_SEARCH), status constants, FSM state enum, CNT_W derivation.
REQ-021 Command queue SHALL be sub-module hash_cmd_fifo (sync FIFO, registered count); FSM, timeout counter, response register in top.

Verification
REQ-022 Insert key 5 value 0xAA to empty table model -> one ht_op_en pulse, rsp_status 00, rsp_value 0.
REQ-023 Search key 5 after REQ-022 -> rsp_value 0xAA, status 00; search key 13 absent -> status 01, value 0.
REQ-024 4 back-to-back commands with rsp_ready=1, then 5th while queue full -> cmd_ready=0 until first pop; op_en pulses spaced >=2 cycles after each op_done.
REQ-025 Model never asserts ht_op_done -> status 10 after exactly TIMEOUT_CYCLES WAIT cycles; next queued op issues normally.
REQ-026 cmd_op 11 -> status 11, ht_op_en stays 0; rsp_ready held low 10 cycles -> rsp_* stable, no new ht_op_en.
REQ-027 rst asserted during WAIT -> next cycle all outputs at reset values, queue empty.

Source files
------------

// File: rtl/hash_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hash_table_pkg
// Purpose  : Shared opcodes, response status codes, client FSM states and the
//            collision-count width used by the hash table client.
// Revision : 1.0 - initial release
// ============================================================================
package hash_table_pkg;

  // Chaining depth of the attached hash table; sets the occupancy port width.
  localparam int CHAINING_SIZE = 8;
  localparam int CNT_W = (CHAINING_SIZE - 1 > 1) ? $clog2(CHAINING_SIZE - 1) : 1;

  // Command / table opcodes.
  localparam logic [1:0] OP_INSERT  = 2'b00;
  localparam logic [1:0] OP_DELETE  = 2'b01;
  localparam logic [1:0] OP_SEARCH  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Response status codes.
  localparam logic [1:0] STS_OK          = 2'b00;
  localparam logic [1:0] STS_TABLE_ERROR = 2'b01;
  localparam logic [1:0] STS_TIMEOUT     = 2'b10;
  localparam logic [1:0] STS_ILLEGAL_OP  = 2'b11;

  // Client sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // True for opcodes the table understands.
  function automatic logic op_is_legal(input logic [1:0] op);
    return (op != OP_ILLEGAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hash_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hash_cmd_fifo
// Purpose  : Synchronous command FIFO with a registered occupancy count.
//            full/empty derive only from the registered count, so a pop in
//            the same cycle never lets a push through a full queue.
// Revision : 1.0 - initial release
// ============================================================================
module hash_cmd_fifo
  import hash_table_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                do_push;
  logic                do_pop;

  assign full     = (count_q == CNT_BITS'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Next-state of storage, pointers and count; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/hash_table_client.sv
`default_nettype none
// ============================================================================
// Module   : hash_table_client
// Purpose  : Queues insert/delete/search commands and sequences them one at a
//            time onto a hash table port, with a completion timeout and a
//            held response register.
// Revision : 1.0 - initial release
// ============================================================================
module hash_table_client
  import hash_table_pkg::*;
#(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [KEY_WIDTH-1:0]   cmd_key,
  input  logic [VALUE_WIDTH-1:0] cmd_value,
  output logic [KEY_WIDTH-1:0]   ht_key_in,
  output logic [VALUE_WIDTH-1:0] ht_value_in,
  output logic [1:0]             ht_op_sel,
  output logic                   ht_op_en,
  input  logic [VALUE_WIDTH-1:0] ht_value_out,
  input  logic                   ht_op_done,
  input  logic                   ht_op_error,
  input  logic [CNT_W-1:0]       ht_collision_count,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_op,
  output logic [KEY_WIDTH-1:0]   rsp_key,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output logic [1:0]             rsp_status,
  output logic                   busy
);

  localparam int CMD_W    = 2 + KEY_WIDTH + VALUE_WIDTH;
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic [1:0]             rsp_status_q, rsp_status_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [CMD_W-1:0]       fifo_wdata;
  logic [CMD_W-1:0]       fifo_rdata;
  logic [1:0]             head_op;
  logic [KEY_WIDTH-1:0]   head_key;
  logic [VALUE_WIDTH-1:0] head_value;

  // Chain occupancy does not influence sequencing; folded here for observability only.
  logic                   unused_collision;
  assign unused_collision = ^ht_collision_count;

  assign fifo_wdata = {cmd_op, cmd_key, cmd_value};
  assign head_op    = fifo_rdata[CMD_W-1 -: 2];
  assign head_key   = fifo_rdata[VALUE_WIDTH +: KEY_WIDTH];
  assign head_value = fifo_rdata[VALUE_WIDTH-1:0];

  hash_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (fifo_wdata),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .empty     (fifo_empty),
    .pop_data  (fifo_rdata)
  );

  // The in-flight registers drive the table directly and only change on a pop
  // in IDLE, which keeps them stable well past the completion cycle. An
  // illegal command is never issued, so its opcode is masked off the table.
  assign cmd_ready   = !fifo_full;
  assign ht_key_in   = key_q;
  assign ht_value_in = value_q;
  assign ht_op_sel   = op_is_legal(op_q) ? op_q : OP_INSERT;
  assign ht_op_en    = (state_q == S_ISSUE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_op      = op_q;
  assign rsp_key     = key_q;
  assign rsp_value   = rsp_value_q;
  assign rsp_status  = rsp_status_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;

  // Sequencing: pop, issue one pulse, wait for completion or timeout, hold response.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    value_d      = value_q;
    tmo_d        = tmo_q;
    rsp_value_d  = rsp_value_q;
    rsp_status_d = rsp_status_q;
    fifo_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head_op;
          key_d    = head_key;
          value_d  = head_value;
          if (!op_is_legal(head_op)) begin
            rsp_status_d = STS_ILLEGAL_OP;
            rsp_value_d  = '0;
            state_d      = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ht_op_done) begin
          rsp_status_d = ht_op_error ? STS_TABLE_ERROR : STS_OK;
          rsp_value_d  = ((op_q == OP_SEARCH) && !ht_op_error) ? ht_value_out : '0;
          state_d      = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_status_d = STS_TIMEOUT;
          rsp_value_d  = '0;
          state_d      = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, in-flight command, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      key_q        <= '0;
      value_q      <= '0;
      tmo_q        <= '0;
      rsp_value_q  <= '0;
      rsp_status_q <= STS_OK;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_q        <= key_d;
      value_q      <= value_d;
      tmo_q        <= tmo_d;
      rsp_value_q  <= rsp_value_d;
      rsp_status_q <= rsp_status_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hash_table_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_table_client
// Purpose  : Randomized self-checking bench for hash_table_client with a
//            behavioural hash table and a response reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hash_table_client;
  import hash_table_pkg::*;

  localparam int KW    = 32;
  localparam int VW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CAP   = 6;
  localparam int M_NORMAL = 0;
  localparam int M_NODONE = 1;
  localparam int M_LATE   = 2;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] value;
    logic [1:0]  status;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [KW-1:0] cmd_key = '0;
  logic [VW-1:0] cmd_value = '0;
  logic [KW-1:0] ht_key_in;
  logic [VW-1:0] ht_value_in;
  logic [1:0]    ht_op_sel;
  logic          ht_op_en;
  logic [VW-1:0] ht_value_out = '0;
  logic          ht_op_done = 1'b0;
  logic          ht_op_error = 1'b0;
  logic [CNT_W-1:0] ht_collision_count = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_op;
  logic [KW-1:0] rsp_key;
  logic [VW-1:0] rsp_value;
  logic [1:0]    rsp_status;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  int last_en_cyc = -100;
  int en_count = 0;
  logic hold_low = 1'b0;

  exp_t expq[$];
  int   mode_q[$];
  logic [31:0] ref_tbl [logic [31:0]];
  logic [31:0] mdl_tbl [logic [31:0]];

  // Table model state
  int          m_cnt = 0;
  int          m_mode = 0;
  logic        m_en_prev = 1'b0;
  logic [1:0]  m_op = '0;
  logic [31:0] m_key = '0;
  logic [31:0] m_val = '0;

  // Monitor state
  logic        have_prev = 1'b0;
  exp_t        prev_rsp;
  logic [31:0] last_val = '0;
  logic [1:0]  last_sts = '0;

  hash_table_client #(
    .KEY_WIDTH      (KW),
    .VALUE_WIDTH    (VW),
    .CMD_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_op             (cmd_op),
    .cmd_key            (cmd_key),
    .cmd_value          (cmd_value),
    .ht_key_in          (ht_key_in),
    .ht_value_in        (ht_value_in),
    .ht_op_sel          (ht_op_sel),
    .ht_op_en           (ht_op_en),
    .ht_value_out       (ht_value_out),
    .ht_op_done         (ht_op_done),
    .ht_op_error        (ht_op_error),
    .ht_collision_count (ht_collision_count),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_op             (rsp_op),
    .rsp_key            (rsp_key),
    .rsp_value          (rsp_value),
    .rsp_status         (rsp_status),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: what the response to a command must be, applied in queue order.
  task automatic expect_push(input logic [1:0] op, input logic [31:0] k,
                             input logic [31:0] v, input int mode);
    exp_t e;
    e.op = op; e.key = k; e.value = '0; e.status = STS_OK;
    if (op == OP_ILLEGAL) begin
      e.status = STS_ILLEGAL_OP;
    end else begin
      mode_q.push_back(mode);
      if (mode != M_NORMAL) begin
        e.status = STS_TIMEOUT;
      end else if (op == OP_INSERT) begin
        if (ref_tbl.exists(k) || ref_tbl.num() < CAP) ref_tbl[k] = v;
        else e.status = STS_TABLE_ERROR;
      end else if (op == OP_DELETE) begin
        if (ref_tbl.exists(k)) ref_tbl.delete(k);
        else e.status = STS_TABLE_ERROR;
      end else begin
        if (ref_tbl.exists(k)) e.value = ref_tbl[k];
        else e.status = STS_TABLE_ERROR;
      end
    end
    expq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send(input logic [1:0] op, input logic [31:0] k,
                      input logic [31:0] v, input int mode);
    int g = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_key = k; cmd_value = v;
    while (!cmd_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) chk("send_ready_timeout", 1, 0);
    else expect_push(op, k, v, mode);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || expq.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) chk("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_rsp_valid();
    int g = 0;
    while (!rsp_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("rsp_valid_timeout", 1, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_ht_op_en"}, ht_op_en, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ht_key_in"}, ht_key_in, 0);
    chk({tag, "_ht_value_in"}, ht_value_in, 0);
    chk({tag, "_ht_op_sel"}, ht_op_sel, 0);
    chk({tag, "_rsp_op"}, rsp_op, 0);
    chk({tag, "_rsp_key"}, rsp_key, 0);
    chk({tag, "_rsp_value"}, rsp_value, 0);
    chk({tag, "_rsp_status"}, rsp_status, 0);
  endtask

  // Behavioural hash table: one op per enable pulse, done after a random latency.
  initial begin
    forever begin
      @(negedge clk);
      if (ht_op_done) begin
        ht_op_done = 1'b0; ht_op_error = 1'b0; ht_value_out = '0;
      end
      if (rst) begin
        m_cnt = 0;
      end else begin
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            chk("key_stable_at_done", ht_key_in, m_key);
            chk("sel_stable_at_done", ht_op_sel, m_op);
            ht_op_done = 1'b1;
            last_done_cyc = cyc;
            ht_op_error = 1'b0;
            ht_value_out = $urandom;
            if (m_mode == M_LATE) begin
              ht_value_out = 32'hDEAD_BEEF;
            end else if (m_op == OP_INSERT) begin
              if (mdl_tbl.exists(m_key) || mdl_tbl.num() < CAP) mdl_tbl[m_key] = m_val;
              else ht_op_error = 1'b1;
            end else if (m_op == OP_DELETE) begin
              if (mdl_tbl.exists(m_key)) mdl_tbl.delete(m_key);
              else ht_op_error = 1'b1;
            end else begin
              if (mdl_tbl.exists(m_key)) ht_value_out = mdl_tbl[m_key];
              else ht_op_error = 1'b1;
            end
          end
        end
        if (ht_op_en) begin
          en_count++;
          chk("op_en_single_cycle", m_en_prev, 0);
          chk("op_en_spacing", (cyc - last_done_cyc) >= 2, 1);
          chk("op_sel_legal", ht_op_sel != OP_ILLEGAL, 1);
          m_op = ht_op_sel; m_key = ht_key_in; m_val = ht_value_in;
          last_en_cyc = cyc;
          if (mode_q.size() == 0) begin
            chk("unexpected_issue", 1, 0);
            m_mode = M_NORMAL;
          end else begin
            m_mode = mode_q.pop_front();
          end
          if (m_mode == M_NORMAL)      m_cnt = $urandom_range(1, 6);
          else if (m_mode == M_LATE)   m_cnt = TMO + 6;
          else                         m_cnt = 0;
        end
      end
      m_en_prev = ht_op_en;
      ht_collision_count = CNT_W'($urandom_range(0, CHAINING_SIZE - 1));
    end
  end

  // Response monitor: drives rsp_ready, checks stability and content.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rst) begin
        have_prev = 1'b0;
      end else if (rsp_valid) begin
        if (have_prev) begin
          chk("rsp_op_stable", rsp_op, prev_rsp.op);
          chk("rsp_key_stable", rsp_key, prev_rsp.key);
          chk("rsp_value_stable", rsp_value, prev_rsp.value);
          chk("rsp_status_stable", rsp_status, prev_rsp.status);
        end else if (expq.size() > 0 && expq[0].status == STS_TIMEOUT) begin
          chk("timeout_latency", cyc - last_en_cyc, TMO + 1);
        end
        if (rsp_ready) begin
          if (expq.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("rsp_op", rsp_op, e.op);
            chk("rsp_key", rsp_key, e.key);
            chk("rsp_value", rsp_value, e.value);
            chk("rsp_status", rsp_status, e.status);
          end
          last_val = rsp_value;
          last_sts = rsp_status;
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev_rsp.op = rsp_op; prev_rsp.key = rsp_key;
          prev_rsp.value = rsp_value; prev_rsp.status = rsp_status;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int acc;
    int g;
    logic [1:0] rop;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // Insert then searches on a fresh table.
    e0 = en_count;
    send(OP_INSERT, 32'd5, 32'hAA, M_NORMAL);
    wait_idle();
    chk("insert_en_pulses", en_count - e0, 1);
    chk("insert_status", last_sts, STS_OK);
    chk("insert_value", last_val, 0);
    send(OP_SEARCH, 32'd5, 32'h0, M_NORMAL);
    wait_idle();
    chk("search5_value", last_val, 32'hAA);
    chk("search5_status", last_sts, STS_OK);
    send(OP_SEARCH, 32'd13, 32'h0, M_NORMAL);
    wait_idle();
    chk("search13_value", last_val, 0);
    chk("search13_status", last_sts, STS_TABLE_ERROR);

    // Table never completes; the next queued op still runs normally.
    send(OP_SEARCH, 32'd5, 32'h0, M_NODONE);
    send(OP_SEARCH, 32'd5, 32'h0, M_NORMAL);
    wait_idle();
    chk("after_timeout_value", last_val, 32'hAA);
    chk("after_timeout_status", last_sts, STS_OK);

    // Late completion arrives while the timeout response is held.
    hold_low = 1'b1;
    send(OP_INSERT, 32'd21, 32'h1, M_LATE);
    wait_rsp_valid();
    repeat (10) @(negedge clk);
    chk("late_rsp_held", rsp_valid, 1);
    chk("late_rsp_status", rsp_status, STS_TIMEOUT);
    hold_low = 1'b0;
    wait_idle();

    // Illegal opcode: never issued, response held under backpressure.
    hold_low = 1'b1;
    e0 = en_count;
    send(OP_ILLEGAL, 32'd77, 32'h5, M_NORMAL);
    wait_rsp_valid();
    repeat (10) @(negedge clk);
    chk("illegal_rsp_valid", rsp_valid, 1);
    chk("illegal_status", rsp_status, STS_ILLEGAL_OP);
    chk("illegal_value", rsp_value, 0);
    chk("illegal_no_issue", en_count - e0, 0);
    hold_low = 1'b0;
    wait_idle();

    // Fill the queue behind a held response.
    hold_low = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1; cmd_op = OP_SEARCH; cmd_key = 32'(i); cmd_value = '0;
      if (cmd_ready) begin
        expect_push(OP_SEARCH, 32'(i), 32'h0, M_NORMAL);
        acc++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("full_accepted", acc, DEPTH + 1);
    chk("full_ready_low", cmd_ready, 0);
    hold_low = 1'b0;
    g = 0;
    while (!cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("ready_after_pop", cmd_ready, 1);
    wait_idle();

    // Reset in WAIT with more commands queued.
    send(OP_INSERT, 32'd9, 32'h55, M_NODONE);
    send(OP_SEARCH, 32'd5, 32'h0, M_NORMAL);
    send(OP_SEARCH, 32'd13, 32'h0, M_NORMAL);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    expq.delete();
    mode_q.delete();
    repeat (6) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? OP_ILLEGAL : 2'($urandom_range(0, 2));
      send(rop, 32'($urandom_range(0, 15)), $urandom, M_NORMAL);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    wait_idle();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
